// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - requester, flush and writeback-stage bundle for writeback_arbiter
interface writeback_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_reg_write;
    logic [NUM_REQ-1:0][5:0]  req_dest_phys_reg_tag;
    logic [NUM_REQ-1:0][31:0] req_data;
    logic [NUM_REQ-1:0][4:0]  req_ROB_index;
    logic [NUM_REQ-1:0]       req_ready;

    logic [4:0]               rob_head_index;
    logic                     flush;

    logic                     wb_valid;
    logic                     wb_reg_write;
    logic [5:0]               wb_dest_phys_reg_tag;
    logic [31:0]              wb_data;
    logic [4:0]               wb_ROB_index;

    modport slave (
        input  req_valid,
        input  req_reg_write,
        input  req_dest_phys_reg_tag,
        input  req_data,
        input  req_ROB_index,
        output req_ready,
        input  rob_head_index,
        input  flush,
        output wb_valid,
        output wb_reg_write,
        output wb_dest_phys_reg_tag,
        output wb_data,
        output wb_ROB_index
    );

    modport master (
        output req_valid,
        output req_reg_write,
        output req_dest_phys_reg_tag,
        output req_data,
        output req_ROB_index,
        input  req_ready,
        output rob_head_index,
        output flush,
        input  wb_valid,
        input  wb_reg_write,
        input  wb_dest_phys_reg_tag,
        input  wb_data,
        input  wb_ROB_index
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - one-of-N writeback arbiter feeding a single registered wb stage
// Round-robin by default; define WB_AGE_PRIORITY_EN to pick the oldest instruction by ROB age.
module writeback_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int LOG_NUM_REQ = $clog2(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               nRST,
    writeback_arbiter_if.slave bus
);
    localparam int PTR_W = (LOG_NUM_REQ > 0) ? LOG_NUM_REQ : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    logic             grant_any;

`ifdef WB_AGE_PRIORITY_EN
    // Age is distance from the ROB head; the 5-bit wrap subtraction handles head wraparound.
    always_comb begin
        logic [4:0] age;
        logic [4:0] best_age;
        found    = 1'b0;
        sel      = '0;
        age      = '0;
        best_age = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age = bus.req_ROB_index[i] - bus.rob_head_index;
            if (bus.req_valid[i] && (!found || (age < best_age))) begin
                found    = 1'b1;
                best_age = age;
                sel      = PTR_W'(i);
            end
        end
    end
`else
    logic unused_rob_head;
    assign unused_rob_head = ^bus.rob_head_index;

    always_comb begin
        int idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PTR_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end
`endif

    // No grant while held in reset or during a flush; consumers never stall otherwise.
    assign grant_any = found && !bus.flush && nRST;

    always_comb begin
        bus.req_ready = '0;
        if (grant_any) begin
            bus.req_ready[sel] = 1'b1;
        end
    end

    assign ptr_next = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : (sel + PTR_W'(1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr                      <= '0;
            bus.wb_valid             <= 1'b0;
            bus.wb_reg_write         <= 1'b0;
            bus.wb_dest_phys_reg_tag <= '0;
            bus.wb_data              <= '0;
            bus.wb_ROB_index         <= '0;
        end else begin
            bus.wb_valid     <= grant_any;
            bus.wb_reg_write <= grant_any && bus.req_reg_write[sel];
            if (grant_any) begin
                ptr                      <= ptr_next;
                bus.wb_dest_phys_reg_tag <= bus.req_dest_phys_reg_tag[sel];
                bus.wb_data              <= bus.req_data[sel];
                bus.wb_ROB_index         <= bus.req_ROB_index[sel];
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    logic CLK;
    logic nRST;
    int   tests_run;
    int   tests_failed;

    writeback_arbiter_if #(.NUM_REQ(3)) bus ();

    writeback_arbiter #(.NUM_REQ(3)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic rw,
                           input logic [5:0] tag, input logic [31:0] data, input logic [4:0] rob);
        bus.req_valid[i]             = v;
        bus.req_reg_write[i]         = rw;
        bus.req_dest_phys_reg_tag[i] = tag;
        bus.req_data[i]              = data;
        bus.req_ROB_index[i]         = rob;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
    endtask

    task automatic load_all();
        set_req(0, 1'b1, 1'b1, 6'd1, 32'h1111_0000, 5'd10);
        set_req(1, 1'b1, 1'b1, 6'd2, 32'h2222_0000, 5'd11);
        set_req(2, 1'b1, 1'b1, 6'd3, 32'h3333_0000, 5'd12);
    endtask

    task automatic test_reset();
        load_all();
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got %b want %b", bus.req_ready, 3'b001);
        end
        tick();
        // Mid-stream: wb stage holds req 0 and the pointer has advanced to 1.
        #2;
        nRST = 1'b0;
        #1;
        tests_run++;
        if ({bus.wb_valid, bus.wb_reg_write, bus.wb_dest_phys_reg_tag, bus.wb_data, bus.wb_ROB_index} !== 45'd0) begin
            tests_failed++;
            $display("FAIL reset_wb_zero: got v=%b rw=%b tag=%0d data=%h rob=%0d want all 0",
                     bus.wb_valid, bus.wb_reg_write, bus.wb_dest_phys_reg_tag, bus.wb_data, bus.wb_ROB_index);
        end
        tests_run++;
        if (bus.req_ready !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready_zero: got %b want %b", bus.req_ready, 3'b000);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL reset_release_grant: got %b want %b", bus.req_ready, 3'b001);
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ready;
        logic [4:0] exp_rob;
        load_all();
        for (int k = 0; k < 6; k++) begin
            exp_ready = 3'b001 << (k % 3);
            exp_rob   = 5'(10 + (k % 3));
            #1;
            tests_run++;
            if (bus.req_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rr_ready_%0d: got %b want %b", k, bus.req_ready, exp_ready);
            end
            tick();
            tests_run++;
            if (bus.wb_valid !== 1'b1 || bus.wb_ROB_index !== exp_rob) begin
                tests_failed++;
                $display("FAIL rr_wb_%0d: got v=%b rob=%0d want v=1 rob=%0d", k, bus.wb_valid, bus.wb_ROB_index, exp_rob);
            end
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_single();
        set_req(2, 1'b1, 1'b1, 6'd17, 32'hDEAD_BEEF, 5'd3);
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_ready: got %b want %b", bus.req_ready, 3'b100);
        end
        tick();
        clear_reqs();
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b1 || bus.wb_dest_phys_reg_tag !== 6'd17 ||
            bus.wb_data !== 32'hDEAD_BEEF || bus.wb_ROB_index !== 5'd3) begin
            tests_failed++;
            $display("FAIL single_wb: got v=%b rw=%b tag=%0d data=%h rob=%0d want v=1 rw=1 tag=17 data=deadbeef rob=3",
                     bus.wb_valid, bus.wb_reg_write, bus.wb_dest_phys_reg_tag, bus.wb_data, bus.wb_ROB_index);
        end
        tick();
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.wb_reg_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: got v=%b rw=%b want v=0 rw=0", bus.wb_valid, bus.wb_reg_write);
        end
    endtask

    task automatic test_no_reg_write();
        set_req(1, 1'b1, 1'b0, 6'd9, 32'h0000_00AA, 5'd7);
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL norw_ready: got %b want %b", bus.req_ready, 3'b010);
        end
        tick();
        clear_reqs();
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b0 || bus.wb_ROB_index !== 5'd7) begin
            tests_failed++;
            $display("FAIL norw_wb: got v=%b rw=%b rob=%0d want v=1 rw=0 rob=7", bus.wb_valid, bus.wb_reg_write, bus.wb_ROB_index);
        end
        tick();
    endtask

    task automatic test_flush();
        set_req(0, 1'b1, 1'b1, 6'd4, 32'h0000_0004, 5'd4);
        set_req(1, 1'b1, 1'b1, 6'd5, 32'h0000_0005, 5'd5);
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL flush_pre_ready: got %b want %b", bus.req_ready, 3'b001);
        end
        tick();
        bus.req_valid[0] = 1'b0;
        bus.flush        = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b000) begin
            tests_failed++;
            $display("FAIL flush_ready: got %b want %b", bus.req_ready, 3'b000);
        end
        tick();
        bus.flush = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.wb_reg_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_wb: got v=%b rw=%b want v=0 rw=0", bus.wb_valid, bus.wb_reg_write);
        end
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL flush_post_ready: got %b want %b", bus.req_ready, 3'b010);
        end
        tick();
        clear_reqs();
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_ROB_index !== 5'd5) begin
            tests_failed++;
            $display("FAIL flush_post_wb: got v=%b rob=%0d want v=1 rob=5", bus.wb_valid, bus.wb_ROB_index);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_ready;
        logic       exp_rw;
        logic [4:0] exp_rob;
        set_req(0, 1'b1, 1'b1, 6'd20, 32'h0000_0020, 5'd20);
        set_req(2, 1'b1, 1'b0, 6'd22, 32'h0000_0022, 5'd22);
        // Pointer sits at 2 after the flush scenario granted req 1.
        for (int k = 0; k < 4; k++) begin
            exp_ready = (k % 2 == 0) ? 3'b100 : 3'b001;
            exp_rw    = (k % 2 == 0) ? 1'b0 : 1'b1;
            exp_rob   = (k % 2 == 0) ? 5'd22 : 5'd20;
            #1;
            tests_run++;
            if (bus.req_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL b2b_ready_%0d: got %b want %b", k, bus.req_ready, exp_ready);
            end
            tick();
            tests_run++;
            if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== exp_rw || bus.wb_ROB_index !== exp_rob) begin
                tests_failed++;
                $display("FAIL b2b_wb_%0d: got v=%b rw=%b rob=%0d want v=1 rw=%b rob=%0d",
                         k, bus.wb_valid, bus.wb_reg_write, bus.wb_ROB_index, exp_rw, exp_rob);
            end
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_age_priority();
        bus.rob_head_index = 5'd30;
        set_req(0, 1'b1, 1'b1, 6'd40, 32'h0000_0040, 5'd2);
        set_req(1, 1'b1, 1'b1, 6'd41, 32'h0000_0041, 5'd31);
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL age_first: got %b want %b", bus.req_ready, 3'b010);
        end
        tick();
        bus.req_valid[1] = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_ROB_index !== 5'd31) begin
            tests_failed++;
            $display("FAIL age_first_wb: got v=%b rob=%0d want v=1 rob=31", bus.wb_valid, bus.wb_ROB_index);
        end
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL age_second: got %b want %b", bus.req_ready, 3'b001);
        end
        tick();
        bus.rob_head_index = 5'd0;
        set_req(0, 1'b1, 1'b1, 6'd40, 32'h0000_0040, 5'd5);
        set_req(2, 1'b1, 1'b1, 6'd42, 32'h0000_0042, 5'd5);
        #1;
        tests_run++;
        if (bus.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL age_tie: got %b want %b", bus.req_ready, 3'b001);
        end
        clear_reqs();
        tick();
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        nRST               = 1'b0;
        bus.req_valid      = '0;
        bus.req_reg_write  = '0;
        bus.req_dest_phys_reg_tag = '0;
        bus.req_data       = '0;
        bus.req_ROB_index  = '0;
        bus.rob_head_index = 5'd0;
        bus.flush          = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        tick();

        test_reset();
`ifndef WB_AGE_PRIORITY_EN
        test_round_robin();
`endif
        test_single();
        test_no_reg_write();
        test_flush();
`ifdef WB_AGE_PRIORITY_EN
        test_age_priority();
`else
        test_back_to_back();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
